and_nina_d2_k2: RTL and testbench

- Masked, fault-redundant AND gadget. Security order d=2, so 3 shares; redundancy k=2, so 3 identical copies per share bit.
- It is the non-linear companion of the combinational NINA XOR gadget. It consumes the same share/copy encoding and feeds XOR gadgets downstream.
- Implements registered domain-oriented masking (DOM-indep) multiplication per redundant copy, with a 2-cycle pipeline.
- Adds a sticky redundancy-mismatch error flag.

---
 rtl/nina_pkg.sv | 23 ++
 rtl/and_nina_d2_k2_if.sv | 49 ++++
 rtl/dom_and_copy.sv | 101 ++++++++++
 rtl/and_nina_d2_k2.sv | 67 ++++++
 tb/tb_and_nina_d2_k2.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nina_pkg.sv
// rtl/nina_pkg.sv - shared constants, types and helpers for the NINA masked gadgets
//
// Purpose : common share/copy encoding used by the NINA XOR and AND gadgets.
//           A share bit is carried as NCOPY identical copies; a fault-free
//           share is therefore either ENC0 (all copies 0) or ENC1 (all 1).
// Ports   : none (package).
package nina_pkg;

  localparam int NSHARE = 3;  // d+1 shares, d = 2
  localparam int NCOPY  = 3;  // k+1 redundant copies, k = 2
  localparam int NRAND  = 3;  // one fresh random bit per share pair (01, 02, 12)

  typedef logic [NCOPY-1:0] share_t;

  localparam share_t ENC0 = 3'b000;
  localparam share_t ENC1 = 3'b111;

  // True when every copy of a share bit agrees.
  function automatic logic is_enc(share_t s);
    return (s == ENC0) || (s == ENC1);
  endfunction

endpackage

// File: rtl/and_nina_d2_k2_if.sv
// rtl/and_nina_d2_k2_if.sv - share/copy bus between an environment and the NINA AND gadget
//
// Purpose : bundles the valid strobes, operand shares, randomness and result
//           shares of and_nina_d2_k2. Every share/random field is NCOPY wide,
//           bit j being redundant copy j.
// Signals : in_valid, port_a_0..2, port_b_0..2, port_r_01/02/12 (environment -> gadget)
//           out_valid, port_c_0..2, err                      (gadget -> environment)
// Modports: master = environment side, slave = gadget side.
interface and_nina_d2_k2_if;
  import nina_pkg::*;

  logic   in_valid;
  share_t port_a_0;
  share_t port_a_1;
  share_t port_a_2;
  share_t port_b_0;
  share_t port_b_1;
  share_t port_b_2;
  share_t port_r_01;
  share_t port_r_02;
  share_t port_r_12;

  logic   out_valid;
  share_t port_c_0;
  share_t port_c_1;
  share_t port_c_2;
  logic   err;

  modport master (
    output in_valid,
    output port_a_0, port_a_1, port_a_2,
    output port_b_0, port_b_1, port_b_2,
    output port_r_01, port_r_02, port_r_12,
    input  out_valid,
    input  port_c_0, port_c_1, port_c_2,
    input  err
  );

  modport slave (
    input  in_valid,
    input  port_a_0, port_a_1, port_a_2,
    input  port_b_0, port_b_1, port_b_2,
    input  port_r_01, port_r_02, port_r_12,
    output out_valid,
    output port_c_0, port_c_1, port_c_2,
    output err
  );

endinterface

// File: rtl/dom_and_copy.sv
// rtl/dom_and_copy.sv - single-copy 3-share DOM-indep AND with two register stages
//
// Purpose : computes one redundant copy of c = a AND b in 3 shares.
//           Stage 1 registers the inner products p_ii and the re-masked
//           cross products z_ik; stage 2 compresses them into the output
//           shares. Only registered operands reach the compression XOR, so
//           glitches on the inputs cannot combine unmasked values.
// Ports   : clk, rst           clock, synchronous active-high reset
//           in_valid_i         inputs valid this cycle
//           a_i[i], b_i[i]     share i of operands a and b (this copy)
//           r_i[0/1/2]         fresh random bit for share pair 01 / 02 / 12
//           c_o[i]             share i of the result (this copy)
//           out_valid_o        c_o holds a new result
module dom_and_copy
  import nina_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [NSHARE-1:0] a_i,
  input  logic [NSHARE-1:0] b_i,
  input  logic [NRAND-1:0]  r_i,
  output logic [NSHARE-1:0] c_o,
  output logic              out_valid_o
);

  // Stage 1 state
  logic [NSHARE-1:0] p_q, p_d;
  logic              z01_q, z01_d;
  logic              z10_q, z10_d;
  logic              z02_q, z02_d;
  logic              z20_q, z20_d;
  logic              z12_q, z12_d;
  logic              z21_q, z21_d;
  logic              v1_q, v1_d;

  // Stage 2 state
  logic [NSHARE-1:0] c_q, c_d;
  logic              vo_q, vo_d;

  always_comb begin
    p_d   = p_q;
    z01_d = z01_q;
    z10_d = z10_q;
    z02_d = z02_q;
    z20_d = z20_q;
    z12_d = z12_q;
    z21_d = z21_q;
    c_d   = c_q;

    // Both cross terms of a pair share the same random bit; it cancels
    // in the unmasked sum but keeps every register value masked.
    if (in_valid_i) begin
      p_d   = a_i & b_i;
      z01_d = (a_i[0] & b_i[1]) ^ r_i[0];
      z10_d = (a_i[1] & b_i[0]) ^ r_i[0];
      z02_d = (a_i[0] & b_i[2]) ^ r_i[1];
      z20_d = (a_i[2] & b_i[0]) ^ r_i[1];
      z12_d = (a_i[1] & b_i[2]) ^ r_i[2];
      z21_d = (a_i[2] & b_i[1]) ^ r_i[2];
    end
    v1_d = in_valid_i;

    if (v1_q) begin
      c_d[0] = p_q[0] ^ z01_q ^ z02_q;
      c_d[1] = p_q[1] ^ z10_q ^ z12_q;
      c_d[2] = p_q[2] ^ z20_q ^ z21_q;
    end
    vo_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      z01_q <= 1'b0;
      z10_q <= 1'b0;
      z02_q <= 1'b0;
      z20_q <= 1'b0;
      z12_q <= 1'b0;
      z21_q <= 1'b0;
      v1_q  <= 1'b0;
      c_q   <= '0;
      vo_q  <= 1'b0;
    end else begin
      p_q   <= p_d;
      z01_q <= z01_d;
      z10_q <= z10_d;
      z02_q <= z02_d;
      z20_q <= z20_d;
      z12_q <= z12_d;
      z21_q <= z21_d;
      v1_q  <= v1_d;
      c_q   <= c_d;
      vo_q  <= vo_d;
    end
  end

  assign c_o         = c_q;
  assign out_valid_o = vo_q;

endmodule

// File: rtl/and_nina_d2_k2.sv
// rtl/and_nina_d2_k2.sv - masked (d=2) fault-redundant (k=2) AND gadget, 2-cycle pipeline
//
// Purpose : one dom_and_copy per redundant copy, each fed bit j of every
//           share, plus a sticky error flag raised when any valid result
//           share has copies that disagree.
// Ports   : clk   clock, rising edge
//           rst   synchronous active-high reset
//           bus   and_nina_d2_k2_if.slave:
//                   in  in_valid, port_a_0..2, port_b_0..2, port_r_01/02/12
//                   out out_valid, port_c_0..2, err
module and_nina_d2_k2
  import nina_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  and_nina_d2_k2_if.slave   bus
);

  logic [NCOPY-1:0]  vld_w;
  logic [NSHARE-1:0] c_w [NCOPY];
  share_t            c0_w, c1_w, c2_w;

  for (genvar j = 0; j < NCOPY; j++) begin : g_copy
    dom_and_copy u_dom (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (bus.in_valid),
      .a_i         ({bus.port_a_2[j], bus.port_a_1[j], bus.port_a_0[j]}),
      .b_i         ({bus.port_b_2[j], bus.port_b_1[j], bus.port_b_0[j]}),
      .r_i         ({bus.port_r_12[j], bus.port_r_02[j], bus.port_r_01[j]}),
      .c_o         (c_w[j]),
      .out_valid_o (vld_w[j])
    );

    // Regroup from per-copy vectors back into per-share vectors.
    assign c0_w[j] = c_w[j][0];
    assign c1_w[j] = c_w[j][1];
    assign c2_w[j] = c_w[j][2];
  end

  // All copies share the same valid pipeline; they agree by construction.
  assign bus.out_valid = &vld_w;
  assign bus.port_c_0  = c0_w;
  assign bus.port_c_1  = c1_w;
  assign bus.port_c_2  = c2_w;

  // Sticky mismatch flag: evaluated on the registered outputs, so it rises
  // on the edge after a bad result appears and holds until reset.
  logic err_q, err_d;
  logic mismatch_w;

  always_comb begin
    mismatch_w = !(is_enc(c0_w) && is_enc(c1_w) && is_enc(c2_w));
    err_d      = err_q | (bus.out_valid & mismatch_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_and_nina_d2_k2.sv
// tb/tb_and_nina_d2_k2.sv - scoreboard testbench for and_nina_d2_k2
module tb_and_nina_d2_k2;
  import nina_pkg::*;

  typedef struct packed {
    share_t c0;
    share_t c1;
    share_t c2;
    share_t u;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exp_t q[$];
  exp_t last_c;
  exp_t item;
  logic m_rst, m_v1, m_ov, m_err;

  and_nina_d2_k2_if bus ();

  and_nina_d2_k2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(share_t a0, share_t a1, share_t a2,
                                 share_t b0, share_t b1, share_t b2,
                                 share_t r01, share_t r02, share_t r12);
    exp_t e;
    e.c0 = (a0 & b0) ^ ((a0 & b1) ^ r01) ^ ((a0 & b2) ^ r02);
    e.c1 = (a1 & b1) ^ ((a1 & b0) ^ r01) ^ ((a1 & b2) ^ r12);
    e.c2 = (a2 & b2) ^ ((a2 & b0) ^ r02) ^ ((a2 & b1) ^ r12);
    e.u  = (a0 ^ a1 ^ a2) & (b0 ^ b1 ^ b2);
    return e;
  endfunction

  function automatic share_t enc(logic v);
    return v ? ENC1 : ENC0;
  endfunction

  function automatic share_t rnd();
    return share_t'($urandom_range(0, 7));
  endfunction

  task automatic drive(input logic v, input share_t a0, input share_t a1, input share_t a2,
                       input share_t b0, input share_t b1, input share_t b2,
                       input share_t r01, input share_t r02, input share_t r12);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.port_a_0  = a0;
    bus.port_a_1  = a1;
    bus.port_a_2  = a2;
    bus.port_b_0  = b0;
    bus.port_b_1  = b1;
    bus.port_b_2  = b2;
    bus.port_r_01 = r01;
    bus.port_r_02 = r02;
    bus.port_r_12 = r12;
    if (v && !rst) q.push_back(model(a0, a1, a2, b0, b1, b2, r01, r02, r12));
  endtask

  // Masked operation on unmasked bits a, b with random share splits and masks.
  task automatic op(input logic a, input logic b);
    logic a1, a2, b1, b2;
    a1 = 1'($urandom_range(0, 1));
    a2 = 1'($urandom_range(0, 1));
    b1 = 1'($urandom_range(0, 1));
    b2 = 1'($urandom_range(0, 1));
    drive(1'b1, enc(a ^ a1 ^ a2), enc(a1), enc(a2), enc(b ^ b1 ^ b2), enc(b1), enc(b2),
          enc(1'($urandom_range(0, 1))), enc(1'($urandom_range(0, 1))),
          enc(1'($urandom_range(0, 1))));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Bench-side valid pipeline and sticky error expectation.
  always @(posedge clk) begin
    m_rst <= rst;
    if (rst) begin
      m_v1  <= 1'b0;
      m_ov  <= 1'b0;
      m_err <= 1'b0;
    end else begin
      m_v1 <= bus.in_valid;
      m_ov <= m_v1;
      if (m_ov && !(is_enc(last_c.c0) && is_enc(last_c.c1) && is_enc(last_c.c2)))
        m_err <= 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_rst) begin
      q.delete();
      last_c = '0;
    end
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("err", 32'(bus.err), 32'(m_err));
    if (m_ov) begin
      check("sb_has_item", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        item = q.pop_front();
        check("c0", 32'(bus.port_c_0), 32'(item.c0));
        check("c1", 32'(bus.port_c_1), 32'(item.c1));
        check("c2", 32'(bus.port_c_2), 32'(item.c2));
        check("unmasked", 32'(bus.port_c_0 ^ bus.port_c_1 ^ bus.port_c_2), 32'(item.u));
        last_c = item;
      end
    end else begin
      check("hold_c0", 32'(bus.port_c_0), 32'(last_c.c0));
      check("hold_c1", 32'(bus.port_c_1), 32'(last_c.c1));
      check("hold_c2", 32'(bus.port_c_2), 32'(last_c.c2));
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last_c = '0;

    // Reset held for two edges with valid random traffic.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.port_a_0  = rnd();
    bus.port_a_1  = rnd();
    bus.port_a_2  = rnd();
    bus.port_b_0  = rnd();
    bus.port_b_1  = rnd();
    bus.port_b_2  = rnd();
    bus.port_r_01 = rnd();
    bus.port_r_02 = rnd();
    bus.port_r_12 = rnd();
    drive(1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_c0", 32'(bus.port_c_0), 32'(ENC0));
    check("rst_c1", 32'(bus.port_c_1), 32'(ENC0));
    check("rst_c2", 32'(bus.port_c_2), 32'(ENC0));
    check("rst_err", 32'(bus.err), 32'(0));
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rel_out_valid", 32'(bus.out_valid), 32'(0));
    check("rel_c0", 32'(bus.port_c_0), 32'(ENC0));
    check("rel_err", 32'(bus.err), 32'(0));

    // Zero randomness: a = (1,0,0), b = (1,1,1).
    drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000);
    idle(2);
    check("zr_out_valid", 32'(bus.out_valid), 32'(1));
    check("zr_c0", 32'(bus.port_c_0), 32'(3'b111));
    check("zr_c1", 32'(bus.port_c_1), 32'(3'b000));
    check("zr_c2", 32'(bus.port_c_2), 32'(3'b000));
    check("zr_err", 32'(bus.err), 32'(0));

    // Nonzero randomness, same operands.
    drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b111);
    idle(2);
    check("nr_out_valid", 32'(bus.out_valid), 32'(1));
    check("nr_c0", 32'(bus.port_c_0), 32'(3'b000));
    check("nr_c1", 32'(bus.port_c_1), 32'(3'b000));
    check("nr_c2", 32'(bus.port_c_2), 32'(3'b111));
    check("nr_err", 32'(bus.err), 32'(0));

    // Streaming, then a one-cycle gap, then two more.
    op(1'b0, 1'b0);
    op(1'b0, 1'b1);
    op(1'b1, 1'b0);
    op(1'b1, 1'b1);
    idle(1);
    op(1'b1, 1'b1);
    op(1'b0, 1'b1);
    idle(3);
    check("st_err", 32'(bus.err), 32'(0));

    // Fault: copy 1 of share a_0 flipped.
    drive(1'b1, 3'b101, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000);
    idle(2);
    check("flt_out_valid", 32'(bus.out_valid), 32'(1));
    check("flt_c0", 32'(bus.port_c_0), 32'(3'b101));
    check("flt_err_pre", 32'(bus.err), 32'(0));
    idle(1);
    check("flt_err_set", 32'(bus.err), 32'(1));
    op(1'b1, 1'b1);
    idle(3);
    check("flt_err_sticky", 32'(bus.err), 32'(1));

    // Reset while the stage-1 valid is set.
    op(1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mr_out_valid", 32'(bus.out_valid), 32'(0));
    check("mr_c0", 32'(bus.port_c_0), 32'(ENC0));
    check("mr_c1", 32'(bus.port_c_1), 32'(ENC0));
    check("mr_c2", 32'(bus.port_c_2), 32'(ENC0));
    check("mr_err", 32'(bus.err), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mr_next_out_valid", 32'(bus.out_valid), 32'(0));

    // Recovery after reset.
    op(1'b1, 1'b1);
    op(1'b0, 1'b0);
    idle(4);
    check("sb_drained", 32'(q.size()), 32'(0));
    check("end_err", 32'(bus.err), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
